fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the main opcode decoder/control unit.
- Holds the PC and fetches from instruction memory over a req/ack handshake.
- Latches the fetched word in an instruction register and drives Inst_31_26 to the control unit.
- Computes next PC from the decoder's Branch/Branch_Not_Equal/Jump and the ALU Zero flag; exposes PC+4 for the jal link write.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/next_pc_calc.sv | 30 +++
 rtl/fetch_unit.sv | 100 ++++++++++
 tb/tb_fetch_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } fetch_state_t;

  // Opcodes of the jump instructions that the fetch stage redirects on.
  localparam logic [5:0] OP_J   = 6'd2;
  localparam logic [5:0] OP_JAL = 6'd3;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump beats branch beats fall-through.
module next_pc_calc (
  input  logic [31:0] PC_plus4,
  input  logic [25:0] Inst_25_0,
  input  logic        Branch,
  input  logic        Branch_Not_Equal,
  input  logic        Jump,
  input  logic        Zero,
  output logic [31:0] next_pc
);

  logic [31:0] branch_off;
  logic        taken;

  // Word offset from the immediate, sign-extended and scaled to bytes.
  assign branch_off = {{14{Inst_25_0[15]}}, Inst_25_0[15:0], 2'b00};
  // beq and bne may both be set; either satisfied condition takes the branch.
  assign taken = (Branch & Zero) | (Branch_Not_Equal & ~Zero);

  // Priority mux; the adder wraps naturally modulo 2^32.
  always_comb begin
    next_pc = PC_plus4;
    if (Jump) begin
      next_pc = {PC_plus4[31:28], Inst_25_0, 2'b00};
    end else if (taken) begin
      next_pc = PC_plus4 + branch_off;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, memory handshake, instruction register,
// next-PC steering and retired-instruction counting.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          COUNT_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        Inst,
  output logic [5:0]         Inst_31_26,
  output logic               inst_valid,
  output logic [31:0]        PC,
  output logic [31:0]        PC_plus4,
  input  logic               Branch,
  input  logic               Branch_Not_Equal,
  input  logic               Jump,
  input  logic               Zero,
  input  logic               exec_done,
  output logic [COUNT_W-1:0] instr_count
);

  fetch_state_t        state_q;
  logic [31:0]         pc_q;
  logic [31:0]         inst_q;
  logic                req_q;
  logic                valid_q;
  logic [COUNT_W-1:0]  count_q;
  logic [31:0]         pc_plus4_d;
  logic [31:0]         next_pc_d;

  assign pc_plus4_d = pc_q + 32'd4;

  next_pc_calc u_next_pc (
    .PC_plus4         (pc_plus4_d),
    .Inst_25_0        (inst_q[25:0]),
    .Branch           (Branch),
    .Branch_Not_Equal (Branch_Not_Equal),
    .Jump             (Jump),
    .Zero             (Zero),
    .next_pc          (next_pc_d)
  );

  // Fetch/execute sequencer; request and valid are registered alongside state
  // so the memory sees glitch-free handshake signals.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= 32'd0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            inst_q  <= imem_rdata;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (exec_done) begin
            pc_q    <= next_pc_d;
            count_q <= count_q + COUNT_W'(1);
            req_q   <= 1'b1;
            valid_q <= 1'b0;
            state_q <= FETCH;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign Inst        = inst_q;
  assign Inst_31_26  = inst_q[31:26];
  assign inst_valid  = valid_q;
  assign PC          = pc_q;
  assign PC_plus4    = pc_plus4_d;
  assign instr_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// instruction streams, checked against a transaction-level reference model.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] Inst;
  logic [5:0]  Inst_31_26;
  logic        inst_valid;
  logic [31:0] PC;
  logic [31:0] PC_plus4;
  logic        Branch = 1'b0;
  logic        Branch_Not_Equal = 1'b0;
  logic        Jump = 1'b0;
  logic        Zero = 1'b0;
  logic        exec_done = 1'b0;
  logic [31:0] instr_count;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_pc = 32'd0;
  logic [31:0] exp_count = 32'd0;

  fetch_unit dut (
    .clk              (clk),
    .reset            (reset),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ack         (imem_ack),
    .imem_rdata       (imem_rdata),
    .Inst             (Inst),
    .Inst_31_26       (Inst_31_26),
    .inst_valid       (inst_valid),
    .PC               (PC),
    .PC_plus4         (PC_plus4),
    .Branch           (Branch),
    .Branch_Not_Equal (Branch_Not_Equal),
    .Jump             (Jump),
    .Zero             (Zero),
    .exec_done        (exec_done),
    .instr_count      (instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural next-PC rule written as plain arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] word,
                                             input bit j, input bit b, input bit bn, input bit z);
    logic [31:0] p4;
    int          off;
    p4  = pc + 32'd4;
    off = int'($signed(word[15:0]));
    if (j)
      return (p4 & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 32'd4);
    else if ((b && z) || (bn && !z))
      return p4 + 32'(off * 4);
    else
      return p4;
  endfunction

  // Randomise the control inputs the DUT must ignore outside the retire edge.
  task automatic scramble_controls();
    Branch           = 1'($urandom);
    Branch_Not_Equal = 1'($urandom);
    Jump             = 1'($urandom);
    Zero             = 1'($urandom);
  endtask

  // One full instruction: fetch with ack delay, optional EXEC stall, retire.
  // Entered and left at a negedge with the DUT expected to be requesting.
  task automatic do_instr(input int dly, input int stall, input logic [31:0] word,
                          input bit j, input bit b, input bit bn, input bit z,
                          input bit has_want, input logic [31:0] want);
    logic [31:0] nxt;
    chk("fetch_req", 32'(imem_req), 32'd1);
    chk("fetch_addr", imem_addr, exp_pc);
    exec_done = 1'b1;
    for (int d = 0; d < dly; d++) begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      scramble_controls();
      @(negedge clk);
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_addr", imem_addr, exp_pc);
      chk("wait_valid", 32'(inst_valid), 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    chk("exec_req", 32'(imem_req), 32'd0);
    chk("exec_valid", 32'(inst_valid), 32'd1);
    chk("exec_inst", Inst, word);
    chk("exec_op", 32'(Inst_31_26), 32'(word[31:26]));
    chk("exec_pc", PC, exp_pc);
    chk("exec_pc4", PC_plus4, exp_pc + 32'd4);
    chk("exec_count", instr_count, exp_count);
    for (int s = 0; s < stall; s++) begin
      exec_done  = 1'b0;
      imem_ack   = 1'($urandom);
      imem_rdata = $urandom;
      scramble_controls();
      @(negedge clk);
      chk("stall_inst", Inst, word);
      chk("stall_pc", PC, exp_pc);
      chk("stall_count", instr_count, exp_count);
      chk("stall_valid", 32'(inst_valid), 32'd1);
      chk("stall_req", 32'(imem_req), 32'd0);
    end
    imem_ack         = 1'($urandom);
    imem_rdata       = $urandom;
    exec_done        = 1'b1;
    Jump             = j;
    Branch           = b;
    Branch_Not_Equal = bn;
    Zero             = z;
    nxt = model_next(exp_pc, word, j, b, bn, z);
    @(negedge clk);
    imem_ack  = 1'b0;
    exp_pc    = nxt;
    exp_count = exp_count + 32'd1;
    scramble_controls();
    chk("retire_req", 32'(imem_req), 32'd1);
    chk("retire_addr", imem_addr, exp_pc);
    chk("retire_valid", 32'(inst_valid), 32'd0);
    chk("retire_count", instr_count, exp_count);
    if (has_want) chk("retire_target", imem_addr, want);
    $display("instr #%0d word=%h j=%0d b=%0d bn=%0d z=%0d dly=%0d stall=%0d -> next=%h",
             exp_count, word, j, b, bn, z, dly, stall, imem_addr);
  endtask

  initial begin
    logic [31:0] w;
    bit rj;

    // Reset held for 3 cycles.
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    reset = 1'b1;
    #1;
    chk("boot_quiet_req", 32'(imem_req), 32'd0);
    chk("boot_count", instr_count, 32'd0);
    chk("boot_inst", Inst, 32'd0);
    chk("boot_op", 32'(Inst_31_26), 32'd0);
    chk("boot_pc", PC, 32'd0);
    @(negedge clk);
    chk("boot_req", 32'(imem_req), 32'd1);
    chk("boot_addr", imem_addr, 32'd0);
    $display("boot: first request at %h", imem_addr);

    // Sequential flow at 0x0, 0x4, 0x8 with zero-wait memory.
    do_instr(0, 0, 32'h0000_0000, 0, 0, 0, 0, 1, 32'h4);
    do_instr(0, 0, 32'h2108_0001, 0, 0, 0, 0, 1, 32'h8);
    do_instr(0, 0, 32'h0000_0020, 0, 0, 0, 0, 1, 32'hC);
    chk("count_after_3", instr_count, 32'd3);

    // Branch scenarios around PC 0x10.
    do_instr(0, 0, {OP_J, 26'h4}, 1, 0, 0, 0, 1, 32'h10);
    do_instr(0, 0, 32'h1000_FFFE, 0, 1, 0, 1, 1, 32'h0C);
    do_instr(0, 0, {OP_J, 26'h4}, 1, 0, 0, 0, 1, 32'h10);
    do_instr(0, 0, 32'h1000_FFFE, 0, 1, 0, 0, 1, 32'h14);
    do_instr(1, 0, {OP_JAL, 26'h4}, 1, 0, 0, 0, 1, 32'h10);
    do_instr(0, 0, 32'h1400_0003, 0, 0, 1, 0, 1, 32'h20);

    // Memory wait of 4 cycles and EXEC stall of 3 cycles, then jump home.
    do_instr(4, 3, {OP_J, 26'h0}, 1, 0, 0, 0, 1, 32'h0);

    // Negative branch wrapping below zero, then jump priority with a high nibble.
    do_instr(0, 0, 32'h1000_FFFD, 0, 1, 0, 1, 1, 32'hFFFF_FFF8);
    do_instr(0, 0, {OP_J, 26'h0000100}, 1, 1, 0, 1, 1, 32'hF000_0400);
    do_instr(0, 0, {OP_J, 26'h3FF_FFFF}, 1, 0, 0, 0, 1, 32'hFFFF_FFFC);
    // PC_plus4 wraps to zero here.
    do_instr(0, 0, 32'h0000_0000, 0, 0, 0, 0, 1, 32'h0);

    // Random instruction stream.
    for (int n = 0; n < 40; n++) begin
      w  = $urandom;
      rj = ($urandom_range(0, 4) == 0);
      if (rj) w[31:26] = ($urandom_range(0, 1) == 0) ? OP_J : OP_JAL;
      do_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), w, rj,
               1'($urandom), 1'($urandom), 1'($urandom), 0, 32'd0);
    end

    // Reset while a fetch is waiting for its ack.
    imem_ack = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("midrst_req_async", 32'(imem_req), 32'd0);
    chk("midrst_count", instr_count, 32'd0);
    chk("midrst_pc", PC, 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_inst", Inst, 32'd0);
    chk("midrst_valid", 32'(inst_valid), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("late_ack_inst", Inst, 32'd0);
    chk("late_ack_valid", 32'(inst_valid), 32'd0);
    chk("restart_req", 32'(imem_req), 32'd1);
    chk("restart_addr", imem_addr, 32'd0);
    $display("reset mid-fetch: restart request at %h", imem_addr);
    exp_pc    = 32'd0;
    exp_count = 32'd0;
    do_instr(2, 1, 32'h0000_0000, 0, 0, 0, 0, 1, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
